// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM state type and default constants for the instruction memory
package imem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
  localparam int IMEM_DATA_W = 32;
  localparam logic [IMEM_DATA_W-1:0] IMEM_HALT_WORD = {IMEM_DATA_W{1'b1}};
  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_WORD = {IMEM_DATA_W{1'b0}};
endpackage

// File: rtl/imem_loader_fetch_if.sv
// imem_loader_fetch_if: loader stream and IF-stage fetch handshake bundle
interface imem_loader_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W = 11
);
  logic load_start, load_valid, load_last, load_ready;
  logic [DATA_W-1:0] load_data;
  logic [CNT_W-1:0] load_count;
  logic fetch_req, fetch_valid, fetch_oob, halted, running;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  modport master (
    output load_start, load_valid, load_last, load_data, fetch_req, fetch_addr,
    input load_ready, load_count, fetch_valid, fetch_data, fetch_oob, halted, running
  );
  modport slave (
    input load_start, load_valid, load_last, load_data, fetch_req, fetch_addr,
    output load_ready, load_count, fetch_valid, fetch_data, fetch_oob, halted, running
  );
endinterface

// File: rtl/imem_ram.sv
// imem_ram: single-port sync-write, registered-read array; IMEM_PARITY_EN adds an even-parity bit per word
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  localparam int PW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst_n,
  input logic we,
  input logic re,
  input logic [PW-1:0] addr,
  input logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
`ifdef IMEM_PARITY_EN
  , output logic perr
`endif
);
`ifdef IMEM_PARITY_EN
  localparam int MW = DATA_W + 1;
  logic [MW-1:0] wword;
  assign wword = {^wdata, wdata};
  assign perr = ^q;
`else
  localparam int MW = DATA_W;
  logic [MW-1:0] wword;
  assign wword = wdata;
`endif
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] q;
  // storage array, deliberately not reset
  always_ff @(posedge clk)
    if (we) mem[addr] <= wword;
  // read register holds its value between reads so fetched data stays stable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (re) q <= mem[addr];
  assign rdata = q[DATA_W-1:0];
endmodule

// File: rtl/imem_loader_fetch.sv
// imem_loader_fetch: load-then-run instruction memory with halt/OOB detection; IMEM_PARITY_EN adds parity_err
module imem_loader_fetch
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
  input logic clk,
  input logic rst_n,
  imem_loader_fetch_if.slave bus
`ifdef IMEM_PARITY_EN
  , output logic parity_err
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = ADDR_W > CW ? ADDR_W : CW;
  state_t state, state_nx;
  logic [PW-1:0] ptr, ptr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic wr, accept, oob, v_q, oob_q, hit;
  logic [DATA_W-1:0] rd_data;
  assign wr = state == LOAD && !bus.load_start && bus.load_valid;
  assign oob = XW'(bus.fetch_addr) >= XW'(cnt);
  assign hit = state == RUN && v_q && !oob_q && rd_data == HALT_WORD;
  assign accept = state == RUN && bus.fetch_req && !bus.load_start && !hit;
`ifdef IMEM_PARITY_EN
  logic rd_perr;
  assign parity_err = v_q && !oob_q && rd_perr;
`endif
  imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr),
    .re(accept && !oob),
    .addr(wr ? ptr : bus.fetch_addr[PW-1:0]),
    .wdata(bus.load_data),
    .rdata(rd_data)
`ifdef IMEM_PARITY_EN
    , .perr(rd_perr)
`endif
  );
  // next state: load_start restarts from any state, loading ends on last word or full array, halt word stops fetch
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    cnt_nx = cnt;
    if (bus.load_start) begin
      state_nx = LOAD;
      ptr_nx = '0;
      cnt_nx = '0;
    end else if (wr) begin
      ptr_nx = ptr + 1'b1;
      cnt_nx = cnt + 1'b1;
      if (bus.load_last || ptr == PW'(DEPTH - 1)) state_nx = RUN;
    end else if (hit) state_nx = HALT;
  end
  // state, load pointer/count and fetch response registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      v_q <= 1'b0;
      oob_q <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      cnt <= cnt_nx;
      v_q <= accept;
      if (accept) oob_q <= oob;
    end
  assign bus.load_ready = state == LOAD;
  assign bus.load_count = cnt;
  assign bus.fetch_valid = v_q;
  assign bus.fetch_oob = v_q && oob_q;
  assign bus.fetch_data = oob_q ? NOP_WORD : rd_data;
  assign bus.halted = state == HALT || hit;
  assign bus.running = state == RUN;
endmodule

// File: tb/tb_imem_loader_fetch.sv
// tb_imem_loader_fetch: directed self-checking bench for imem_loader_fetch
module tb_imem_loader_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  imem_loader_fetch_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(11)) bus ();
  imem_loader_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last = 1'b0;
    bus.load_data = '0;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL reset_load_ready: got %b expected 0", bus.load_ready); end
    n_cmp++; if (bus.load_count !== 11'd0) begin n_err++; $display("FAIL reset_load_count: got %0d expected 0", bus.load_count); end
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fetch_valid: got %b expected 0", bus.fetch_valid); end
    n_cmp++; if (bus.fetch_data !== 32'h0) begin n_err++; $display("FAIL reset_fetch_data: got %h expected 00000000", bus.fetch_data); end
    n_cmp++; if (bus.fetch_oob !== 1'b0) begin n_err++; $display("FAIL reset_fetch_oob: got %b expected 0", bus.fetch_oob); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b expected 0", bus.running); end
    rst_n = 1'b1;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL idle_fetch_ignored: got %b expected 0", bus.fetch_valid); end
  endtask

  task automatic test_load4();
    logic [31:0] prog [4] = '{32'h00011020, 32'h00611020, 32'h00221820, 32'hFFFFFFFF};
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_in_load: got %b expected 1", bus.load_ready); end
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data = prog[i];
      bus.load_last = (i == 3);
      tick();
    end
    idle_inputs();
    n_cmp++; if (bus.load_count !== 11'd4) begin n_err++; $display("FAIL load4_count: got %0d expected 4", bus.load_count); end
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL load4_running: got %b expected 1", bus.running); end
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL load4_ready: got %b expected 0", bus.load_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3] = '{32'h00011020, 32'h00611020, 32'h00221820};
    for (int i = 0; i < 3; i++) begin
      bus.fetch_req = 1'b1;
      bus.fetch_addr = 32'(i);
      tick();
      n_cmp++; if (bus.fetch_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.fetch_valid); end
      n_cmp++; if (bus.fetch_data !== exp[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, bus.fetch_data, exp[i]); end
    end
    bus.fetch_req = 1'b0;
    tick();
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop: got %b expected 0", bus.fetch_valid); end
    n_cmp++; if (bus.fetch_data !== 32'h00221820) begin n_err++; $display("FAIL b2b_data_hold: got %h expected 00221820", bus.fetch_data); end
  endtask

  task automatic test_oob();
    logic [31:0] addrs [3] = '{32'h7, 32'h400, 32'h80000001};
    for (int i = 0; i < 3; i++) begin
      bus.fetch_req = 1'b1;
      bus.fetch_addr = addrs[i];
      tick();
      n_cmp++; if (bus.fetch_valid !== 1'b1) begin n_err++; $display("FAIL oob_valid[%h]: got %b expected 1", addrs[i], bus.fetch_valid); end
      n_cmp++; if (bus.fetch_oob !== 1'b1) begin n_err++; $display("FAIL oob_flag[%h]: got %b expected 1", addrs[i], bus.fetch_oob); end
      n_cmp++; if (bus.fetch_data !== 32'h0) begin n_err++; $display("FAIL oob_data[%h]: got %h expected 00000000", addrs[i], bus.fetch_data); end
    end
    bus.fetch_req = 1'b0;
  endtask

  task automatic test_halt();
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 32'd3;
    tick();
    bus.fetch_addr = 32'd0;
    n_cmp++; if (bus.fetch_valid !== 1'b1) begin n_err++; $display("FAIL halt_valid: got %b expected 1", bus.fetch_valid); end
    n_cmp++; if (bus.fetch_data !== 32'hFFFFFFFF) begin n_err++; $display("FAIL halt_data: got %h expected ffffffff", bus.fetch_data); end
    n_cmp++; if (bus.fetch_oob !== 1'b0) begin n_err++; $display("FAIL halt_oob: got %b expected 0", bus.fetch_oob); end
    n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL halt_flag: got %b expected 1", bus.halted); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL halt_no_fetch[%0d]: got %b expected 0", i, bus.fetch_valid); end
      n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky[%0d]: got %b expected 1", i, bus.halted); end
    end
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL halt_running: got %b expected 0", bus.running); end
    bus.fetch_req = 1'b0;
  endtask

  task automatic test_full_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL reload_halted_clear: got %b expected 0", bus.halted); end
    n_cmp++; if (bus.load_count !== 11'd0) begin n_err++; $display("FAIL reload_count_clear: got %0d expected 0", bus.load_count); end
    for (int i = 0; i < 1024; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data = 32'hA5000000 | 32'(i);
      tick();
    end
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL full_running: got %b expected 1", bus.running); end
    n_cmp++; if (bus.load_count !== 11'd1024) begin n_err++; $display("FAIL full_count: got %0d expected 1024", bus.load_count); end
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", bus.load_ready); end
    bus.load_data = 32'h12345678;
    tick();
    bus.load_valid = 1'b0;
    n_cmp++; if (bus.load_count !== 11'd1024) begin n_err++; $display("FAIL full_extra_ignored: got %0d expected 1024", bus.load_count); end
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 32'd1023;
    tick();
    n_cmp++; if (bus.fetch_data !== 32'hA50003FF || bus.fetch_oob !== 1'b0) begin n_err++; $display("FAIL full_last_word: got %h oob %b expected a50003ff oob 0", bus.fetch_data, bus.fetch_oob); end
    bus.fetch_addr = 32'd1024;
    tick();
    n_cmp++; if (bus.fetch_oob !== 1'b1 || bus.fetch_data !== 32'h0) begin n_err++; $display("FAIL full_oob: got %h oob %b expected 00000000 oob 1", bus.fetch_data, bus.fetch_oob); end
    bus.fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data = 32'h11;
    tick();
    bus.load_data = 32'h22;
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.load_count !== 11'd0) begin n_err++; $display("FAIL midrst_count: got %0d expected 0", bus.load_count); end
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b expected 0", bus.load_ready); end
    n_cmp++; if (bus.running !== 1'b0 || bus.halted !== 1'b0 || bus.fetch_valid !== 1'b0 || bus.fetch_oob !== 1'b0 || bus.fetch_data !== 32'h0) begin
      n_err++; $display("FAIL midrst_outputs: got run %b halt %b v %b oob %b data %h expected all 0", bus.running, bus.halted, bus.fetch_valid, bus.fetch_oob, bus.fetch_data);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start_vs_fetch();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data = 32'h11;
    tick();
    bus.load_data = 32'h22;
    bus.load_last = 1'b1;
    tick();
    idle_inputs();
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 32'd1;
    tick();
    n_cmp++; if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h22) begin n_err++; $display("FAIL prestart_fetch: got v %b data %h expected v 1 data 00000022", bus.fetch_valid, bus.fetch_data); end
    bus.load_start = 1'b1;
    tick();
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL start_drops_fetch: got %b expected 0", bus.fetch_valid); end
    n_cmp++; if (bus.load_ready !== 1'b1 || bus.running !== 1'b0) begin n_err++; $display("FAIL start_to_load: got ready %b run %b expected ready 1 run 0", bus.load_ready, bus.running); end
    bus.fetch_req = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data = 32'h33;
    tick();
    n_cmp++; if (bus.load_count !== 11'd0) begin n_err++; $display("FAIL restart_drops_word: got %0d expected 0", bus.load_count); end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load4();
    test_back_to_back();
    test_oob();
    test_halt();
    test_full_load();
    test_reset_mid_load();
    test_start_vs_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
